// File: rtl/axis_pkg.sv
// ----------------------------------------------------------------------------
// axis_pkg: shared arbiter state encoding and stream defaults (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

package axis_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  localparam int DEFAULT_DW = 8;

endpackage

`default_nettype wire

// File: rtl/axis_rr_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick: combinational round-robin picker, first requester after last_idx (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last_idx,
  output logic           any,
  output logic [IDW-1:0] idx
);

  logic [IDW:0] pos;

  // Walk the ring backwards so the nearest requester after last_idx wins.
  always_comb begin
    any = 1'b0;
    idx = '0;
    pos = '0;
    for (int k = N; k >= 1; k--) begin
      pos = {1'b0, last_idx} + (IDW+1)'(k);
      if (pos >= (IDW+1)'(N)) begin
        pos = pos - (IDW+1)'(N);
      end
      if (req[pos[IDW-1:0]]) begin
        any = 1'b1;
        idx = pos[IDW-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/axis_rr_arbiter.sv
// ----------------------------------------------------------------------------
// axis_rr_arbiter: packet-level round-robin AXI-Stream N:1 arbiter (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module axis_rr_arbiter
  import axis_pkg::*;
#(
  parameter int N         = 4,
  parameter int DW        = DEFAULT_DW,
  parameter int MAX_BEATS = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]    s_tvalid,
  input  logic [N*DW-1:0] s_tdata,
  input  logic [N-1:0]    s_tlast,
  output logic [N-1:0]    s_tready,
  output logic            m_tvalid,
  output logic [DW-1:0]   m_tdata,
  output logic            m_tlast,
  input  logic            m_tready,
  output logic [N-1:0]    grant,
  output logic            busy,
  output logic            overlen_err
);

  localparam int IDW = $clog2(N);
  localparam int CW  = $clog2(MAX_BEATS + 1);

  arb_state_t     state;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] last_idx;
  logic [CW-1:0]  beat_cnt;

  logic           pick_any;
  logic [IDW-1:0] pick_idx;
  logic           in_grant;
  logic           at_limit;
  logic           beat_ok;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_rr_pick (
    .req      (s_tvalid),
    .last_idx (last_idx),
    .any      (pick_any),
    .idx      (pick_idx)
  );

  // Pure pass-through of the granted source; nothing is buffered here.
  always_comb begin
    in_grant = (state == ST_GRANT);
    at_limit = (beat_cnt == CW'(MAX_BEATS - 1));
    m_tvalid = in_grant & s_tvalid[grant_idx];
    m_tlast  = in_grant & (s_tlast[grant_idx] | at_limit);
    m_tdata  = '0;
    s_tready = '0;
    grant    = '0;
    for (int i = 0; i < N; i++) begin
      if (in_grant && (grant_idx == IDW'(i))) begin
        m_tdata     = s_tdata[i*DW +: DW];
        s_tready[i] = m_tready;
        grant[i]    = 1'b1;
      end
    end
    busy    = in_grant;
    beat_ok = m_tvalid & m_tready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      grant_idx   <= '0;
      last_idx    <= IDW'(N - 1);
      beat_cnt    <= '0;
      overlen_err <= 1'b0;
    end else begin
      overlen_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant_idx <= pick_idx;
            beat_cnt  <= '0;
            state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (beat_ok) begin
            if (m_tlast) begin
              state       <= ST_IDLE;
              last_idx    <= grant_idx;
              beat_cnt    <= '0;
              overlen_err <= ~s_tlast[grant_idx];
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axis_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_axis_rr_arbiter: directed scenarios plus randomized model comparison (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module tb_axis_rr_arbiter;

  localparam int N         = 4;
  localparam int DW        = 8;
  localparam int MAX_BEATS = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    s_tvalid = '0;
  logic [N*DW-1:0] s_tdata  = '0;
  logic [N-1:0]    s_tlast  = '0;
  logic [N-1:0]    s_tready;
  logic            m_tvalid;
  logic [DW-1:0]   m_tdata;
  logic            m_tlast;
  logic            m_tready = 1'b0;
  logic [N-1:0]    grant;
  logic            busy;
  logic            overlen_err;

  int pass_cnt  = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  axis_rr_arbiter #(
    .N         (N),
    .DW        (DW),
    .MAX_BEATS (MAX_BEATS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_tvalid    (s_tvalid),
    .s_tdata     (s_tdata),
    .s_tlast     (s_tlast),
    .s_tready    (s_tready),
    .m_tvalid    (m_tvalid),
    .m_tdata     (m_tdata),
    .m_tlast     (m_tlast),
    .m_tready    (m_tready),
    .grant       (grant),
    .busy        (busy),
    .overlen_err (overlen_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; s_tvalid = '0; s_tlast = '0; m_tready = 1'b0;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; s_tvalid = 4'hF; s_tlast = 4'hF; m_tready = 1'b1;
    tick; tick;
    check_cnt++; if (grant !== 4'b0000) $display("FAIL reset_grant got %b want 0000", grant); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    check_cnt++; if (overlen_err !== 1'b0) $display("FAIL reset_err got %b want 0", overlen_err); else pass_cnt++;
    check_cnt++; if (m_tvalid !== 1'b0) $display("FAIL reset_mvalid got %b want 0", m_tvalid); else pass_cnt++;
    check_cnt++; if (m_tlast !== 1'b0) $display("FAIL reset_mlast got %b want 0", m_tlast); else pass_cnt++;
    check_cnt++; if (s_tready !== 4'b0000) $display("FAIL reset_sready got %b want 0000", s_tready); else pass_cnt++;
    rst = 1'b0; s_tvalid = '0; s_tlast = '0;
  endtask

  task automatic test_single;
    do_reset;
    m_tready = 1'b1;
    s_tvalid = 4'b0010; s_tdata[15:8] = 8'hA0; s_tlast[1] = 1'b0;
    #1;
    check_cnt++; if (grant !== 4'b0000) $display("FAIL single_req_cycle got %b want 0000", grant); else pass_cnt++;
    tick;
    for (int b = 0; b < 3; b++) begin
      s_tdata[15:8] = 8'hA0 + 8'(b); s_tlast[1] = (b == 2);
      #1;
      check_cnt++; if (grant !== 4'b0010) $display("FAIL single_grant beat %0d got %b want 0010", b, grant); else pass_cnt++;
      check_cnt++; if (m_tdata !== 8'hA0 + 8'(b)) $display("FAIL single_data beat %0d got %h want %h", b, m_tdata, 8'hA0 + 8'(b)); else pass_cnt++;
      check_cnt++; if (m_tlast !== (b == 2)) $display("FAIL single_last beat %0d got %b want %b", b, m_tlast, (b == 2)); else pass_cnt++;
      tick;
    end
    s_tvalid = '0; s_tlast = '0;
    #1;
    check_cnt++; if (grant !== 4'b0000) $display("FAIL single_release got %b want 0000", grant); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("FAIL single_busy got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_fairness;
    int beat[N];
    int src;
    logic [N-1:0] exp_g;
    logic [N-1:0] acc;
    do_reset;
    m_tready = 1'b1;
    for (int i = 0; i < N; i++) begin
      beat[i] = 0; s_tdata[i*DW +: DW] = {4'(i), 4'h0}; s_tlast[i] = 1'b0;
    end
    s_tvalid = 4'hF;
    // Expected pattern: idle cycle, two beats of one source, rotating 0,1,2,3,0
    for (int c = 0; c < 15; c++) begin
      #1;
      src   = (c / 3) % N;
      exp_g = (c % 3 == 0) ? 4'b0000 : (4'b0001 << src);
      check_cnt++; if (grant !== exp_g) $display("FAIL fair_grant cyc %0d got %b want %b", c, grant, exp_g); else pass_cnt++;
      if (c % 3 != 0) begin
        check_cnt++; if (m_tdata !== {4'(src), 4'(beat[src])}) $display("FAIL fair_data cyc %0d got %h want %h", c, m_tdata, {4'(src), 4'(beat[src])}); else pass_cnt++;
        check_cnt++; if (m_tlast !== (c % 3 == 2)) $display("FAIL fair_last cyc %0d got %b want %b", c, m_tlast, (c % 3 == 2)); else pass_cnt++;
      end
      acc = s_tvalid & s_tready;
      tick;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          beat[i]++;
          s_tdata[i*DW +: DW] = {4'(i), 4'(beat[i])};
          s_tlast[i] = beat[i][0];
        end
      end
    end
    s_tvalid = '0; s_tlast = '0;
  endtask

  task automatic test_backpressure;
    logic [4:0] pat;
    logic       acc;
    int         beat;
    pat = 5'b11001;
    beat = 0;
    do_reset;
    s_tvalid = 4'b0100; s_tdata[23:16] = 8'h20; s_tlast = '0;
    tick;
    s_tvalid = 4'hF;
    for (int c = 0; c < 5; c++) begin
      m_tready = pat[c]; s_tdata[23:16] = 8'h20 + 8'(beat); s_tlast[2] = (beat == 2);
      #1;
      check_cnt++; if (grant !== 4'b0100) $display("FAIL bp_grant cyc %0d got %b want 0100", c, grant); else pass_cnt++;
      check_cnt++; if (s_tready !== (pat[c] ? 4'b0100 : 4'b0000)) $display("FAIL bp_sready cyc %0d got %b want %b", c, s_tready, (pat[c] ? 4'b0100 : 4'b0000)); else pass_cnt++;
      check_cnt++; if (m_tdata !== 8'h20 + 8'(beat)) $display("FAIL bp_data cyc %0d got %h want %h", c, m_tdata, 8'h20 + 8'(beat)); else pass_cnt++;
      acc = m_tvalid & m_tready;
      tick;
      if (acc) beat++;
    end
    check_cnt++; if (beat != 3) $display("FAIL bp_beats got %0d want 3", beat); else pass_cnt++;
    check_cnt++; if (grant !== 4'b0000) $display("FAIL bp_release got %b want 0000", grant); else pass_cnt++;
    s_tvalid = '0; s_tlast = '0;
  endtask

  task automatic test_overlen;
    do_reset;
    m_tready = 1'b1;
    s_tvalid = 4'b1100; s_tdata[31:24] = 8'h30; s_tdata[23:16] = 8'h40; s_tlast = '0;
    tick;
    for (int b = 0; b < MAX_BEATS; b++) begin
      s_tdata[23:16] = 8'h40 + 8'(b);
      #1;
      check_cnt++; if (m_tlast !== (b == MAX_BEATS - 1)) $display("FAIL ovl_last beat %0d got %b want %b", b, m_tlast, (b == MAX_BEATS - 1)); else pass_cnt++;
      check_cnt++; if (overlen_err !== 1'b0) $display("FAIL ovl_early_err beat %0d got %b want 0", b, overlen_err); else pass_cnt++;
      tick;
    end
    s_tdata[23:16] = 8'h50;
    #1;
    check_cnt++; if (overlen_err !== 1'b1) $display("FAIL ovl_err_pulse got %b want 1", overlen_err); else pass_cnt++;
    check_cnt++; if (grant !== 4'b0000) $display("FAIL ovl_idle got %b want 0000", grant); else pass_cnt++;
    tick;
    check_cnt++; if (overlen_err !== 1'b0) $display("FAIL ovl_err_width got %b want 0", overlen_err); else pass_cnt++;
    check_cnt++; if (grant !== 4'b1000) $display("FAIL ovl_next_grant got %b want 1000", grant); else pass_cnt++;
    s_tvalid = '0;
  endtask

  task automatic test_reset_mid;
    do_reset;
    m_tready = 1'b1;
    s_tvalid = 4'b0001; s_tdata[7:0] = 8'h60; s_tlast = '0;
    tick;
    for (int b = 0; b < 2; b++) begin
      s_tdata[7:0] = 8'h60 + 8'(b);
      #1;
      check_cnt++; if (m_tdata !== 8'h60 + 8'(b)) $display("FAIL rmid_data beat %0d got %h want %h", b, m_tdata, 8'h60 + 8'(b)); else pass_cnt++;
      tick;
    end
    s_tdata[7:0] = 8'h62; rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    check_cnt++; if (grant !== 4'b0000) $display("FAIL rmid_grant got %b want 0000", grant); else pass_cnt++;
    check_cnt++; if (m_tvalid !== 1'b0) $display("FAIL rmid_mvalid got %b want 0", m_tvalid); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", busy); else pass_cnt++;
    s_tvalid = 4'b0011; s_tdata[7:0] = 8'h60;
    tick;
    check_cnt++; if (grant !== 4'b0001) $display("FAIL rmid_regrant got %b want 0001", grant); else pass_cnt++;
    s_tvalid = '0;
    tick;
  endtask

  task automatic test_gap;
    logic gap;
    int   bidx;
    do_reset;
    m_tready = 1'b1;
    s_tvalid = 4'b1010; s_tdata[15:8] = 8'h70; s_tdata[31:24] = 8'h33; s_tlast = '0;
    tick;
    for (int c = 0; c < 7; c++) begin
      gap  = (c >= 2) && (c <= 4);
      bidx = (c < 2) ? c : c - 3;
      s_tvalid[1] = !gap; s_tdata[15:8] = 8'h70 + 8'(bidx); s_tlast[1] = (bidx == 3) && !gap;
      #1;
      check_cnt++; if (grant !== 4'b0010) $display("FAIL gap_grant cyc %0d got %b want 0010", c, grant); else pass_cnt++;
      check_cnt++; if (m_tvalid !== !gap) $display("FAIL gap_mvalid cyc %0d got %b want %b", c, m_tvalid, !gap); else pass_cnt++;
      check_cnt++; if (s_tready[3] !== 1'b0) $display("FAIL gap_sready3 cyc %0d got %b want 0", c, s_tready[3]); else pass_cnt++;
      tick;
    end
    s_tvalid[1] = 1'b0; s_tlast = '0;
    #1;
    check_cnt++; if (grant !== 4'b0000) $display("FAIL gap_idle got %b want 0000", grant); else pass_cnt++;
    tick;
    check_cnt++; if (grant !== 4'b1000) $display("FAIL gap_next got %b want 1000", grant); else pass_cnt++;
    s_tvalid = '0;
  endtask

  // Reference: owner index (-1 idle), beats sent in current grant, last winner.
  task automatic test_random;
    int owner, mcnt, mlast, acc_src, c;
    int plen[N];
    int ppos[N];
    logic [7:0]   seq[N];
    logic         err_exp, next_err, tl;
    logic [N-1:0] exp_g, exp_sr;
    logic         exp_mv;
    do_reset;
    owner = -1; mcnt = 0; mlast = N - 1; err_exp = 1'b0; acc_src = -1;
    for (int i = 0; i < N; i++) begin
      plen[i] = $urandom_range(1, 20); ppos[i] = 0; seq[i] = 8'(i << 6);
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (acc_src >= 0) begin
        seq[acc_src]++;
        ppos[acc_src]++;
        if (ppos[acc_src] == plen[acc_src]) begin
          ppos[acc_src] = 0; plen[acc_src] = $urandom_range(1, 20);
        end
        if ($urandom_range(0, 3) == 0) s_tvalid[acc_src] = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (!s_tvalid[i] && ($urandom_range(0, 2) == 0)) s_tvalid[i] = 1'b1;
        s_tdata[i*DW +: DW] = seq[i];
        s_tlast[i] = (ppos[i] == plen[i] - 1);
      end
      m_tready = ($urandom_range(0, 3) != 0);
      #1;
      exp_g = '0; exp_sr = '0; exp_mv = 1'b0;
      if (owner >= 0) begin
        exp_g[owner] = 1'b1;
        exp_sr[owner] = m_tready;
        exp_mv = s_tvalid[owner];
      end
      check_cnt++; if (grant !== exp_g) $display("FAIL rnd_grant cyc %0d got %b want %b", cyc, grant, exp_g); else pass_cnt++;
      check_cnt++; if (busy !== (owner >= 0)) $display("FAIL rnd_busy cyc %0d got %b want %b", cyc, busy, (owner >= 0)); else pass_cnt++;
      check_cnt++; if (s_tready !== exp_sr) $display("FAIL rnd_sready cyc %0d got %b want %b", cyc, s_tready, exp_sr); else pass_cnt++;
      check_cnt++; if (m_tvalid !== exp_mv) $display("FAIL rnd_mvalid cyc %0d got %b want %b", cyc, m_tvalid, exp_mv); else pass_cnt++;
      check_cnt++; if (overlen_err !== err_exp) $display("FAIL rnd_err cyc %0d got %b want %b", cyc, overlen_err, err_exp); else pass_cnt++;
      if (exp_mv) begin
        tl = s_tlast[owner] || (mcnt == MAX_BEATS - 1);
        check_cnt++; if (m_tdata !== seq[owner]) $display("FAIL rnd_data cyc %0d got %h want %h", cyc, m_tdata, seq[owner]); else pass_cnt++;
        check_cnt++; if (m_tlast !== tl) $display("FAIL rnd_last cyc %0d got %b want %b", cyc, m_tlast, tl); else pass_cnt++;
      end
      next_err = 1'b0; acc_src = -1;
      if (owner < 0) begin
        for (int k = 1; k <= N; k++) begin
          c = (mlast + k) % N;
          if ((owner < 0) && s_tvalid[c]) owner = c;
        end
      end else if (s_tvalid[owner] && m_tready) begin
        acc_src = owner;
        if (s_tlast[owner] || (mcnt == MAX_BEATS - 1)) begin
          next_err = !s_tlast[owner];
          mlast = owner; owner = -1; mcnt = 0;
        end else begin
          mcnt++;
        end
      end
      err_exp = next_err;
      tick;
    end
    s_tvalid = '0; s_tlast = '0; m_tready = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_fairness;
    test_backpressure;
    test_overlen;
    test_reset_mid;
    test_gap;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
Packet-level round-robin arbiter that shares one 8-bit AXI-Stream output between N AXI-Stream masters, for example several stream-master instances feeding one downstream slave. It grants one source at a time and holds that grant until the packet completes, which is the handshake beat with tlast. It also enforces a maximum packet length. Grant and error status are exported for debug and monitoring.

Parameters:
N, 4, number of requesting sources (2..8)
DW, 8, tdata width per source
MAX_BEATS, 16, maximum beats per packet; the beat at this count is force-terminated
IDW, $clog2(N), width of the grant index (derived, not overridden)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous, active-high reset
s_tvalid  in  N  per-source valid
s_tdata  in  N*DW  packed source data; source i occupies bits [i*DW +: DW]
s_tlast  in  N  per-source last
s_tready  out  N  per-source ready; only the granted bit can be high
m_tvalid  out  1  output valid
m_tdata  out  DW  output data
m_tlast  out  1  output last, either passed through or forced
m_tready  in  1  downstream ready
grant  out  N  one-hot grant, 0 when idle
busy  out  1  high in the GRANT state
overlen_err  out  1  one-cycle pulse when a packet is force-terminated

Behaviour:
- Reset values:
  - State IDLE; grant=0; busy=0; overlen_err=0.
  - last_idx=N-1, so source 0 has the highest priority after reset.
  - beat_cnt=0.
  - All m_* outputs and s_tready are 0.
- IDLE state:
  - All s_tready=0 and m_tvalid=0.
  - If any s_tvalid is high, select the first i with s_tvalid[i]=1, scanning (last_idx+1)..(last_idx+N) mod N.
  - On that cycle register grant_idx=i and go to GRANT. Arbitration latency is 1 cycle: the first beat can pass on the cycle after the request is seen.
  - If no s_tvalid is high, stay in IDLE.
- GRANT state (g = grant_idx):
  - Combinational pass-through: m_tvalid=s_tvalid[g], m_tdata=s_tdata[g], s_tready[g]=m_tready.
  - All other s_tready bits stay 0.
  - grant=1<<g; busy=1.
  - A beat is accepted when m_tvalid && m_tready. On each accepted beat, beat_cnt increments.
  - m_tlast = s_tlast[g] OR (beat_cnt==MAX_BEATS-1).
  - Accepted beat with m_tlast=1:
    - Next state IDLE; last_idx=g; beat_cnt=0.
    - overlen_err pulses next cycle only if the termination was forced (s_tlast[g]=0).
  - Source deasserts tvalid mid-packet: stay in GRANT and keep the grant. There is no timeout.
  - Downstream stall (m_tready=0): hold everything. AXI stability is the source's responsibility; the arbiter adds no storage.
- Changes to s_tvalid on non-granted sources while in GRANT have no effect.
- Simultaneous requests are resolved by round-robin order only.
  - Example: N=4, last_idx=1, all requesting gives the order 2,3,0,1.
- A single-beat packet (tlast on the first beat) is legal. Its grant lasts until that beat is accepted, then IDLE for 1 cycle. This 1-cycle idle gap between packets is required.
- Reset asserted mid-packet: everything returns to reset values on the next edge. The partial packet is dropped with no forced tlast.
- beat_cnt width is $clog2(MAX_BEATS+1). It never exceeds MAX_BEATS-1 while in GRANT.

Decomposition:
- Shared package axis_pkg: state encoding (IDLE=0, GRANT=1) and default DW.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req[N], last_idx.
  - Outputs: any, idx.
  - Instantiated once. Reusable for other shared-resource arbiters.

Test Plan:
- Single source: source 1 sends a 3-beat packet A0,A1,A2 with tlast on A2 and m_tready=1. Required: grant=4'b0010 the cycle after the request, m_tdata=A0,A1,A2 on consecutive cycles, m_tlast only on A2, then grant=0.
- Fairness: all 4 sources hold valid with 2-beat packets. Required: after reset the grant order is 0,1,2,3,0, each packet is contiguous, and there is 1 idle cycle between packets.
- Backpressure: m_tready toggles 1,0,0,1 during a granted packet. Required: s_tready[g] mirrors m_tready, no beat is lost or duplicated, and non-granted s_tready stays 0 throughout.
- Over-length: source 2 streams 20 beats and never asserts tlast, MAX_BEATS=16. Required: m_tlast=1 on beat 16, overlen_err pulses 1 cycle, and the next grant goes to a different requesting source (source 3 if requesting).
- Reset mid-packet: rst is asserted for 1 cycle during beat 2 of a 5-beat packet from source 0. Required: next cycle grant=0, m_tvalid=0, busy=0, and source 0 wins again if it is still requesting.
- Gap in source valid: the granted source drops tvalid for 3 cycles mid-packet while source 3 is requesting. Required: the grant is held, m_tvalid=0 during the gap, and source 3 is not served until the tlast beat is accepted.
